// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC generator plus a DEPTH-entry circular prefetch queue
// feeding decode. Instruction memory is read combinationally at the current PC
// and the word is pushed the same cycle. A taken redirect flushes the queue and
// reloads the PC.
// Optional build macro: FETCH_ALIGN_CHK_EN -- force redirect targets onto a word
// boundary and tag the first entry fetched after a misaligned redirect with adel.
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    output logic [31:0]                imem_addr,
    output logic                       imem_en,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_pc8,
    output logic                       out_adel,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Next-PC helpers: sequential advance wraps at 32 bits.
    function automatic logic [31:0] pc_plus(input logic [31:0] base, input logic [31:0] inc);
        return base + inc;
    endfunction

    // PC value a redirect loads; word-aligned when the alignment check is built in.
    function automatic logic [31:0] redirect_pc(input logic [31:0] target);
`ifdef FETCH_ALIGN_CHK_EN
        return target & ~32'h3;
`else
        return target;
`endif
    endfunction

    logic [31:0]   pc = RESET_PC;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          push;

    // Queue storage holds data only; it is never reset because cnt gates validity.
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
`ifdef FETCH_ALIGN_CHK_EN
    logic          mem_adel  [DEPTH];
    logic          adel_pending;
`endif

    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full queue can still stream.
    assign push      = fetch_en && !redirect_valid && ((cnt < FULL) || pop);

    assign imem_en   = push;
    assign imem_addr = pc;
    assign count     = cnt;

    assign out_pc    = mem_pc[rd_ptr];
    assign out_instr = mem_instr[rd_ptr];
    assign out_pc8   = pc_plus(mem_pc[rd_ptr], 32'd8);
`ifdef FETCH_ALIGN_CHK_EN
    assign out_adel  = mem_adel[rd_ptr];
`else
    assign out_adel  = 1'b0;
`endif

    // Control state: PC, pointers, occupancy; reset beats redirect beats fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            adel_pending <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Any pop this cycle has already handed its head to decode; flush now.
            pc     <= redirect_pc(redirect_target);
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
`ifdef FETCH_ALIGN_CHK_EN
            adel_pending <= |redirect_target[1:0];
`endif
        end else begin
            if (push) begin
                pc     <= pc_plus(pc, 32'd4);
                wr_ptr <= wr_ptr + PW'(1);
`ifdef FETCH_ALIGN_CHK_EN
                adel_pending <= 1'b0;
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Queue write port: capture the fetched word with its PC at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= imem_rdata;
`ifdef FETCH_ALIGN_CHK_EN
            mem_adel[wr_ptr]  <= adel_pending;
`endif
        end
    end

endmodule
